// File: rtl/vga_tile_renderer.sv
// VGA tile renderer: beam counters drive the tile-map read port, and a two-stage
// pipeline turns tile codes into palette RGB with sync and frame tick kept aligned.
module vga_tile_renderer #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned TILE_LOG2 = 4,
   parameter int unsigned ADDR_W    = 11,
   parameter int unsigned TILE_W    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] raddr,
   output logic              re,
   input  logic [TILE_W-1:0] rdata,
   output logic              hsync,
   output logic              vsync,
   output logic              blank_n,
   output logic [3:0]        r,
   output logic [3:0]        g,
   output logic [3:0]        b,
   output logic              frame_tick
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0]     H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]     V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0]     VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [ADDR_W-1:0] COLS   = ADDR_W'(H_ACTIVE >> TILE_LOG2);

   // stage 0: beam position and tile row base
   logic [HW-1:0]     hcnt_q, hcnt_d;
   logic [VW-1:0]     vcnt_q, vcnt_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic              h_wrap, v_wrap, v_vis, active;
   logic              hs_raw, vs_raw, tick_raw;

   // stage 1: control delayed to line up with rdata
   logic              act1_q, hs1_q, vs1_q, tick1_q;

   // stage 2: output pins
   logic              blank_q, hsync_q, vsync_q, tick_q;
   logic [11:0]       rgb_q, rgb_d;

   always_comb begin
      h_wrap     = (hcnt_q == H_LAST);
      v_wrap     = (vcnt_q == V_LAST);
      v_vis      = (vcnt_q < V_VIS);
      active     = (hcnt_q < H_VIS) && v_vis;
      hcnt_d     = h_wrap ? '0 : hcnt_q + HW'(1);
      vcnt_d     = vcnt_q;
      row_base_d = row_base_q;
      if (h_wrap) begin
         vcnt_d = v_wrap ? '0 : vcnt_q + VW'(1);
         // advance one tile row after the last scanline of each visible tile row
         if (v_wrap) begin
            row_base_d = '0;
         end else if ((&vcnt_q[TILE_LOG2-1:0]) && v_vis) begin
            row_base_d = row_base_q + COLS;
         end
      end
   end

   always_comb begin
      raddr    = row_base_q + ADDR_W'(hcnt_q >> TILE_LOG2);
      re       = active & ~reset;
      hs_raw   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vs_raw   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
      tick_raw = (hcnt_q == '0) && (vcnt_q == V_VIS);
   end

   always_comb begin
      rgb_d = '0;
      if (act1_q) begin
         case (32'(rdata))
            32'd1:   rgb_d = 12'h0F0;
            32'd2:   rgb_d = 12'h8F8;
            32'd3:   rgb_d = 12'hF00;
            default: rgb_d = 12'h000;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         row_base_q <= '0;
         act1_q     <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         tick1_q    <= 1'b0;
         blank_q    <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         tick_q     <= 1'b0;
         rgb_q      <= '0;
      end else begin
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         row_base_q <= row_base_d;
         act1_q     <= active;
         hs1_q      <= hs_raw;
         vs1_q      <= vs_raw;
         tick1_q    <= tick_raw;
         blank_q    <= act1_q;
         hsync_q    <= hs1_q;
         vsync_q    <= vs1_q;
         tick_q     <= tick1_q;
         rgb_q      <= rgb_d;
      end
   end

   assign blank_n    = blank_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign frame_tick = tick_q;
   assign r          = rgb_q[11:8];
   assign g          = rgb_q[7:4];
   assign b          = rgb_q[3:0];

endmodule
